// File: rtl/decimate_accum.sv
// rtl/decimate_accum.sv - block averager (decimate by DECIM) feeding a 2-entry output FIFO
module decimate_accum #(
    parameter int DECIM = 4
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic signed [7:0] input_0,
    input  logic              in_valid,
    output logic signed [7:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int SH = $clog2(DECIM);
    localparam int AW = 8 + SH;

    logic [SH-1:0]        phase_q;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sum;
    logic signed [7:0]    result;
    logic                 last;
    logic                 push;
    logic                 pop;

    logic signed [7:0]    head_q;
    logic signed [7:0]    tail_q;
    logic [1:0]           level_q;
    logic                 overflow_q;

    // The sum of a full block of 8-bit samples always fits in AW bits, and the
    // arithmetic shift by SH is just a bit-select of that sum (floor division).
    assign sum    = acc_q + {{SH{input_0[7]}}, input_0};
    assign result = sum[SH+7:SH];
    assign last   = (phase_q == SH'(DECIM - 1));
    assign push   = in_valid && last;
    assign pop    = out_valid && out_ready;

    assign out_valid = (level_q != 2'd0);
    assign out_data  = out_valid ? head_q : 8'sd0;
    assign overflow  = overflow_q;

    // Accumulate valid samples; a completed block clears phase and accumulator.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            acc_q   <= '0;
            phase_q <= '0;
        end else if (in_valid) begin
            if (last) begin
                acc_q   <= '0;
                phase_q <= '0;
            end else begin
                acc_q   <= sum;
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    // Two-entry FIFO: head_q is always the oldest entry, tail_q the second one.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else if (push && pop) begin
            // pop implies level >= 1, so the level never changes here
            if (level_q == 2'd1) begin
                head_q <= result;
            end else begin
                head_q <= tail_q;
                tail_q <= result;
            end
        end else if (push) begin
            case (level_q)
                2'd0: begin
                    head_q  <= result;
                    level_q <= 2'd1;
                end
                2'd1: begin
                    tail_q  <= result;
                    level_q <= 2'd2;
                end
                default: overflow_q <= 1'b1;
            endcase
        end else if (pop) begin
            head_q  <= tail_q;
            level_q <= level_q - 2'd1;
        end
    end

endmodule

// File: tb/tb_decimate_accum.sv
// tb/tb_decimate_accum.sv - randomized scoreboard bench for decimate_accum
module tb_decimate_accum;

    localparam int DECIM = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [7:0] input_0 = 8'sd0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    int q[$];
    int m_sum = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    decimate_accum #(.DECIM(DECIM)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .input_0        (input_0),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int floor_avg(input int s);
        int r;
        r = s / DECIM;
        if ((s % DECIM != 0) && (s < 0)) r = r - 1;
        return r;
    endfunction

    // Reference model: collects samples per block, keeps the expected FIFO contents.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (in_valid) begin
            m_sum += int'(input_0);
            m_cnt++;
            if (m_cnt == DECIM) begin
                if (q.size() < 2) q.push_back(floor_avg(m_sum));
                else m_ovf = 1'b1;
                m_sum = 0;
                m_cnt = 0;
            end
        end
    end

    // Monitor: compares outputs mid-cycle and retires the head the next edge will pop.
    always @(negedge clk) begin
        if (mon_en) begin
            bit ev;
            int ed;
            ev = (q.size() != 0);
            ed = ev ? q[0] : 0;
            check("out_valid", int'(out_valid), int'(ev));
            check("out_data", int'(out_data), ed);
            check("overflow", int'(overflow), int'(m_ovf));
            if (ev && out_ready && !rst) void'(q.pop_front());
        end
    end

    task automatic step(input bit r, input bit v, input int x, input bit rdy);
        rst       = r;
        in_valid  = v;
        input_0   = 8'(x);
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input int a, input int b, input int c, input int d, input bit rdy);
        step(1'b0, 1'b1, a, rdy);
        step(1'b0, 1'b1, b, rdy);
        step(1'b0, 1'b1, c, rdy);
        step(1'b0, 1'b1, d, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_data", int'(out_data), 0);
        check("reset_ovf", int'(overflow), 0);

        // basic average with one-cycle latency
        blk(10, 20, 30, 40, 1'b1);
        check("avg_25_valid", int'(out_valid), 1);
        check("avg_25", int'(out_data), 25);
        step(1'b0, 1'b0, 0, 1'b1);
        check("avg_25_gone", int'(out_valid), 0);

        blk(-1, -1, -1, -2, 1'b1);
        check("floor_neg2", int'(out_data), -2);
        blk(-128, -128, -128, -128, 1'b1);
        check("min_128", int'(out_data), -128);
        blk(127, 127, 127, 127, 1'b1);
        check("max_127", int'(out_data), 127);

        // gaps between valid samples
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4, 1'b1);
            if (i < 3) for (int g = 0; g <= i; g++) step(1'b0, 1'b0, 99, 1'b1);
        end
        check("gap_avg_4", int'(out_data), 4);
        step(1'b0, 1'b0, 0, 1'b1);

        // overflow: three blocks with no consumer
        blk(8, 8, 8, 8, 1'b0);
        blk(8, 8, 8, 8, 1'b0);
        blk(8, 8, 8, 8, 1'b0);
        check("ovf_set", int'(overflow), 1);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        check("ovf_sticky", int'(overflow), 1);
        check("drained", int'(out_valid), 0);

        // push and pop together at level 2
        do_reset();
        blk(1, 1, 1, 1, 1'b0);
        blk(2, 2, 2, 2, 1'b0);
        step(1'b0, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 3, 1'b1);
        check("pp_head", int'(out_data), 2);
        check("pp_no_ovf", int'(overflow), 0);
        step(1'b0, 1'b0, 0, 1'b1);
        check("pp_next", int'(out_data), 3);
        step(1'b0, 1'b0, 0, 1'b1);

        // reset abandons a partial block; a sample during reset is discarded
        step(1'b0, 1'b1, 100, 1'b1);
        step(1'b0, 1'b1, 100, 1'b1);
        step(1'b1, 1'b1, 100, 1'b1);
        blk(0, 0, 0, 0, 1'b1);
        check("rst_partial", int'(out_data), 0);
        step(1'b1, 1'b1, 120, 1'b1);
        step(1'b0, 1'b1, 120, 1'b1);
        step(1'b0, 1'b1, 120, 1'b1);
        step(1'b0, 1'b1, 120, 1'b1);
        check("rst_sample_dropped", int'(out_valid), 0);
        step(1'b0, 1'b1, 120, 1'b1);
        check("rst_sample_block", int'(out_data), 120);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int x;
            x = (($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : -128)
                                             : int'($urandom_range(0, 255)) - 128);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), x,
                 ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decimate_accum.md
DECIMATE_ACCUM -- requirements
Module: decimate_accum

Interface
REQ-001 SHALL have parameter DECIM, default 4: number of input samples averaged per output; legal values 2, 4, 8, 16.
REQ-002 SHALL have port system1000, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port system1000_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port input_0, input, 8 bits signed: sample from the upstream feedback-loop stage.
REQ-005 SHALL have port in_valid, input, 1 bit: input_0 carries a sample this cycle; there is no back-pressure, so samples are never stalled.
REQ-006 SHALL have port out_data, output, 8 bits signed: average at the FIFO head.
REQ-007 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag, set when a completed average is dropped.

Function
REQ-010 SHALL keep a phase counter, range 0..DECIM-1, and a signed accumulator of 8+log2(DECIM) bits (max 12); neither shall ever wrap or overflow.
REQ-011 In-valid sample, phase < DECIM-1: SHALL add the sign-extended input_0 to the accumulator and increment phase.
REQ-012 In-valid sample, phase = DECIM-1 (block complete):
- compute result = (acc + input_0) arithmetic-shifted right by log2(DECIM), i.e. floor division, truncated to 8 bits (always representable);
- push result into the output FIFO;
- clear acc and phase to 0 in the same cycle.
REQ-013 in_valid low: acc and phase SHALL hold.
REQ-014 Output FIFO SHALL be 2 entries deep, fully registered.
- out_valid = (level != 0).
- out_data = head entry when out_valid = 1; 8'sd0 when out_valid = 0.
REQ-015 Pop: SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-016 Latency, FIFO empty: the result SHALL appear on out_data/out_valid in the cycle after the edge that clocked the final sample of the block.
REQ-017 Simultaneous push and pop:
- at any level, SHALL keep level unchanged with correct ordering;
- at level 2, SHALL drop nothing.
REQ-018 Push at level 2 without a pop: SHALL discard the new result, keep both stored entries, and set overflow to 1.
REQ-019 overflow SHALL remain 1 until reset.
REQ-020 Pop at level 0: SHALL have no effect.
REQ-021 FIFO order SHALL be first-in first-out; the head entry SHALL stay stable while out_valid = 1 and out_ready = 0.

Reset
REQ-022 When system1000_rst = 1 at an edge, SHALL set: acc = 0, phase = 0, FIFO level = 0, out_valid = 0, out_data = 0, overflow = 0.
REQ-023 A sample presented in the same cycle as reset SHALL be discarded; a partial block SHALL be abandoned, and the next valid sample starts a fresh block.
REQ-024 Reset SHALL take priority over push, pop and accumulate.

Verification (DECIM=4 unless stated)
REQ-025 Reset; in_valid=1 with samples 10,20,30,40 on consecutive cycles; out_ready=1 -> one cycle after 40: out_valid=1, out_data=25 for exactly one cycle, then out_valid=0, out_data=0.
REQ-026 Samples -1,-1,-1,-2 -> out_data=-2 (sum -5, floor division); four samples of -128 -> -128; four samples of 127 -> 127; no wrap.
REQ-027 Samples 4,4,4,4 with in_valid low for 1-3 cycles between samples -> exactly one output, 4, one cycle after the 4th valid sample; acc and phase hold during the gaps.
REQ-028 out_ready=0; three blocks of all-8 samples -> level 2 and overflow=1 after the third block; then out_ready=1 -> outputs 8, 8 on consecutive cycles, then out_valid=0; overflow stays 1.
REQ-029 Level 2 with out_ready=1 when a block completes -> push and pop in the same cycle, level stays 2, overflow stays 0.
REQ-030 Reset after 2 samples of 100, then samples 0,0,0,0 -> output 0 (not 50); reset with in_valid=1 -> that sample does not count toward the block.
